// File: rtl/hamming74_pkg.sv
// Shared definitions for the Hamming(7,4) link: word widths, the transmit
// FSM state type, the encoder and the error-injection mask helper.
package hamming74_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_e;

    // Data bits sit in y[6:3]; parity bits y[2:0] make the syndrome zero.
    function automatic logic [CW_W-1:0] encode74(input logic [DATA_W-1:0] d);
        encode74 = {d[3], d[2], d[1], d[0],
                    d[2] ^ d[1] ^ d[0],
                    d[3] ^ d[2] ^ d[0],
                    d[3] ^ d[1] ^ d[0]};
    endfunction

    // Position p (1..7) selects codeword bit y[p-1]; 0 selects nothing.
    function automatic logic [CW_W-1:0] inj_mask(input logic [2:0] pos);
        if (pos == 3'd0) begin
            inj_mask = 7'b000_0000;
        end else begin
            inj_mask = 7'b000_0001 << (pos - 3'd1);
        end
    endfunction

endpackage

// File: rtl/hamming74_tx_if.sv
// Handshake, parallel codeword and serial frame signals of hamming74_tx.
// The slave modport is the encoder side; master is whoever feeds it.
interface hamming74_tx_if;
    import hamming74_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [CW_W-1:0]   cw_out;
    logic              cw_valid;
    logic              ser_out;
    logic              ser_valid;
    logic              ser_sof;
    logic              ser_eof;
    logic              busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, cw_out, cw_valid, ser_out, ser_valid,
               ser_sof, ser_eof, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, cw_out, cw_valid, ser_out, ser_valid,
               ser_sof, ser_eof, busy
    );

endinterface

// File: rtl/hamming74_ser.sv
// Frame serializer: loads a 7-bit word and shifts it out, each bit held for
// BIT_DIV cycles. All outputs are registered and appear the cycle after load.
module hamming74_ser
    import hamming74_pkg::*;
#(
    parameter int BIT_DIV   = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic [CW_W-1:0] i_word,
    output logic            o_ser,
    output logic            o_valid,
    output logic            o_sof,
    output logic            o_eof,
    output logic            o_done
);

    localparam int               DIV_W    = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [2:0]       BIT_LAST = 3'd6;

    logic [CW_W-1:0]  r_word;
    logic [2:0]       r_bit;
    logic [DIV_W-1:0] r_div;
    logic             r_active;
    logic             r_ser;
    logic             r_sof;
    logic             r_eof;
    logic             r_done;

    logic [CW_W-1:0]  w_word_nxt;
    logic [2:0]       w_bit_nxt;
    logic [DIV_W-1:0] w_div_nxt;
    logic             w_active_nxt;
    logic [2:0]       w_idx;

    // Advance the divide and bit counters; a load restarts at bit 0.
    always_comb begin
        w_word_nxt   = r_word;
        w_bit_nxt    = r_bit;
        w_div_nxt    = r_div;
        w_active_nxt = r_active;
        if (i_load) begin
            w_word_nxt   = i_word;
            w_bit_nxt    = 3'd0;
            w_div_nxt    = DIV_ZERO;
            w_active_nxt = 1'b1;
        end else if (r_active) begin
            if (r_div == DIV_LAST) begin
                w_div_nxt = DIV_ZERO;
                if (r_bit == BIT_LAST) begin
                    w_active_nxt = 1'b0;
                    w_bit_nxt    = 3'd0;
                end else begin
                    w_bit_nxt = r_bit + 3'd1;
                end
            end else begin
                w_div_nxt = r_div + DIV_ONE;
            end
        end else begin
            w_active_nxt = 1'b0;
        end
    end

    // Map frame position to codeword bit index according to bit order.
    always_comb begin
        if (MSB_FIRST != 0) begin
            w_idx = 3'd6 - w_bit_nxt;
        end else begin
            w_idx = w_bit_nxt;
        end
    end

    // Counter state and registered line outputs; idle line is held at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_word   <= 7'b000_0000;
            r_bit    <= 3'd0;
            r_div    <= DIV_ZERO;
            r_active <= 1'b0;
            r_ser    <= 1'b0;
            r_sof    <= 1'b0;
            r_eof    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_word   <= w_word_nxt;
            r_bit    <= w_bit_nxt;
            r_div    <= w_div_nxt;
            r_active <= w_active_nxt;
            r_ser    <= w_active_nxt & w_word_nxt[w_idx];
            r_sof    <= w_active_nxt & (w_bit_nxt == 3'd0);
            r_eof    <= w_active_nxt & (w_bit_nxt == BIT_LAST);
            r_done   <= w_active_nxt & (w_bit_nxt == BIT_LAST) & (w_div_nxt == DIV_LAST);
        end
    end

    assign o_ser   = r_ser;
    assign o_valid = r_active;
    assign o_sof   = r_sof;
    assign o_eof   = r_eof;
    assign o_done  = r_done;

endmodule

// File: rtl/hamming74_tx.sv
// Hamming(7,4) transmitter: accepts 4-bit words over valid/ready, presents
// the registered codeword with a one-cycle strobe and serializes it with
// start/end-of-frame markers, followed by an optional idle gap.
// Optional macro HAMMING74_ERRINJ_EN adds inj_pos[2:0] to flip one codeword
// bit (sampled at the handshake) for exercising the downstream corrector.
module hamming74_tx
    import hamming74_pkg::*;
#(
    parameter int BIT_DIV    = 1,
    parameter int GAP_CYCLES = 0,
    parameter int MSB_FIRST  = 1
) (
    input  logic          clk,
    input  logic          reset,
    hamming74_tx_if.slave bus
`ifdef HAMMING74_ERRINJ_EN
    ,
    input  logic [2:0]    inj_pos
`endif
);

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);

    tx_state_e        r_state;
    tx_state_e        w_state_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_cnt_nxt;
    logic [CW_W-1:0]  r_cw;
    logic             r_cw_valid;
    logic             r_in_ready;
    logic             r_busy;
    logic [CW_W-1:0]  w_cw;
    logic [CW_W-1:0]  w_cw_nxt;
    logic             w_in_ready_nxt;
    logic             w_busy_nxt;
    logic             w_hs;
    logic             w_ser_done;
    logic             w_ser;
    logic             w_ser_valid;
    logic             w_ser_sof;
    logic             w_ser_eof;

    // in_ready is only ever high in IDLE, so this alone qualifies a transfer.
    assign w_hs = bus.in_valid & r_in_ready;

    // Codeword for the word on the input, with the optional single-bit flip.
    always_comb begin
`ifdef HAMMING74_ERRINJ_EN
        w_cw = encode74(bus.in_data) ^ inj_mask(inj_pos);
`else
        w_cw = encode74(bus.in_data);
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: frame after handshake, then optional gap, then idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                if (w_ser_done) begin
                    w_state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GAP;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM outputs, computed from the next state so they can be registered.
    always_comb begin
        w_in_ready_nxt = (w_state_nxt == IDLE);
        w_busy_nxt     = (w_state_nxt != IDLE);
        if ((r_state == GAP) && (w_state_nxt == GAP)) begin
            w_gap_cnt_nxt = r_gap_cnt + GAP_ONE;
        end else begin
            w_gap_cnt_nxt = GAP_ZERO;
        end
        if (w_hs) begin
            w_cw_nxt = w_cw;
        end else begin
            w_cw_nxt = r_cw;
        end
    end

    // Registered handshake, status and parallel codeword outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gap_cnt  <= GAP_ZERO;
            r_cw       <= 7'b000_0000;
            r_cw_valid <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_cw       <= w_cw_nxt;
            r_cw_valid <= w_hs;
            r_in_ready <= w_in_ready_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    hamming74_ser #(
        .BIT_DIV   (BIT_DIV),
        .MSB_FIRST (MSB_FIRST)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_hs),
        .i_word  (w_cw),
        .o_ser   (w_ser),
        .o_valid (w_ser_valid),
        .o_sof   (w_ser_sof),
        .o_eof   (w_ser_eof),
        .o_done  (w_ser_done)
    );

    assign bus.in_ready  = r_in_ready;
    assign bus.cw_out    = r_cw;
    assign bus.cw_valid  = r_cw_valid;
    assign bus.ser_out   = w_ser;
    assign bus.ser_valid = w_ser_valid;
    assign bus.ser_sof   = w_ser_sof;
    assign bus.ser_eof   = w_ser_eof;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_hamming74_tx.sv
// Bench for hamming74_tx: two instances (BIT_DIV=1/GAP=0/MSB first and
// BIT_DIV=3/GAP=2/LSB first), each with a frame-level reference model that
// predicts every output on every cycle, plus directed literal checks.
module tb_hamming74_tx;

    typedef struct packed {
        logic v;
        logic sof;
        logic eof;
        logic ser;
    } exp_t;

    logic       clk = 1'b0;
    logic       tb_reset;
    logic [2:0] tb_inj;
    logic [3:0] tb_data  [2];
    logic       tb_valid [2];
    logic [6:0] o_cw     [2];
    logic       o_cwv    [2];
    logic       o_ready  [2];
    logic       o_ser    [2];
    logic       o_sv     [2];
    logic       o_sof    [2];
    logic       o_eof    [2];
    logic       o_busy   [2];
    int         n_vec  = 0;
    int         n_miss = 0;

    always #5 clk = ~clk;

    function automatic logic [2:0] syndrome(input logic [6:0] y);
        return {y[5] ^ y[4] ^ y[3] ^ y[2],
                y[6] ^ y[5] ^ y[3] ^ y[1],
                y[6] ^ y[4] ^ y[3] ^ y[0]};
    endfunction

    // Reference encoder: the unique word with data on top and zero syndrome.
    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        logic [6:0] y;
        ref_encode = 7'b0;
        for (int p = 0; p < 8; p++) begin
            y = {d, 3'(p)};
            if (syndrome(y) == 3'b000) ref_encode = y;
        end
    endfunction

    function automatic logic [6:0] ref_mask(input logic [2:0] p);
        logic [6:0] one = 7'd1;
        return (p == 3'd0) ? 7'd0 : (one << (p - 3'd1));
    endfunction

    task automatic chk(input string name, input int inst, input logic [6:0] act,
                       input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s[%0d] t=%0t: got %b expected %b", name, inst, $time, act, exp);
        end
    endtask

    task automatic wait_ready(input int inst);
        int n = 0;
        while (o_ready[inst] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", inst, 7'(o_ready[inst]), 7'd1);
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int BD  = (gi == 0) ? 1 : 3;
        localparam int GP  = (gi == 0) ? 0 : 2;
        localparam int MSB = (gi == 0) ? 1 : 0;

        hamming74_tx_if bus ();

        assign bus.in_data  = tb_data[gi];
        assign bus.in_valid = tb_valid[gi];
        assign o_cw[gi]     = bus.cw_out;
        assign o_cwv[gi]    = bus.cw_valid;
        assign o_ready[gi]  = bus.in_ready;
        assign o_ser[gi]    = bus.ser_out;
        assign o_sv[gi]     = bus.ser_valid;
        assign o_sof[gi]    = bus.ser_sof;
        assign o_eof[gi]    = bus.ser_eof;
        assign o_busy[gi]   = bus.busy;

        hamming74_tx #(
            .BIT_DIV    (BD),
            .GAP_CYCLES (GP),
            .MSB_FIRST  (MSB)
        ) u_dut (
            .clk   (clk),
            .reset (tb_reset),
            .bus   (bus)
`ifdef HAMMING74_ERRINJ_EN
            ,
            .inj_pos (tb_inj)
`endif
        );

        // Model: queue of expected line values, one entry per upcoming cycle.
        exp_t       q[$];
        logic [6:0] m_cw    = 7'd0;
        logic       m_cwv   = 1'b0;
        logic       m_ready = 1'b0;
        bit         armed   = 1'b0;

        initial begin
            exp_t       ent;
            logic [6:0] cw;
            logic       hs;
            forever begin
                @(posedge clk);
                if (tb_reset) begin
                    q.delete();
                    m_cw    = 7'd0;
                    m_cwv   = 1'b0;
                    m_ready = 1'b0;
                    armed   = 1'b1;
                end else begin
                    hs = m_ready && tb_valid[gi];
                    if (q.size() > 0) void'(q.pop_front());
                    m_cwv = 1'b0;
                    if (hs) begin
                        cw = ref_encode(tb_data[gi]);
`ifdef HAMMING74_ERRINJ_EN
                        cw = cw ^ ref_mask(tb_inj);
`endif
                        m_cw  = cw;
                        m_cwv = 1'b1;
                        for (int k = 0; k < 7; k++) begin
                            for (int r = 0; r < BD; r++) begin
                                ent.v   = 1'b1;
                                ent.sof = (k == 0);
                                ent.eof = (k == 6);
                                ent.ser = (MSB != 0) ? cw[6-k] : cw[k];
                                q.push_back(ent);
                            end
                        end
                        for (int g = 0; g < GP; g++) begin
                            ent = exp_t'(4'b0000);
                            q.push_back(ent);
                        end
                    end
                    m_ready = (q.size() == 0);
                end
            end
        end

        // Compare every output against the model on each falling edge.
        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (armed) begin
                    e = (q.size() > 0) ? q[0] : exp_t'(4'b0000);
                    chk("ser_valid", gi, 7'(bus.ser_valid), 7'(e.v));
                    chk("ser_out",   gi, 7'(bus.ser_out),   7'(e.ser));
                    chk("ser_sof",   gi, 7'(bus.ser_sof),   7'(e.sof));
                    chk("ser_eof",   gi, 7'(bus.ser_eof),   7'(e.eof));
                    chk("in_ready",  gi, 7'(bus.in_ready),  7'(m_ready));
                    chk("busy",      gi, 7'(bus.busy),      7'(q.size() > 0));
                    chk("cw_out",    gi, bus.cw_out,        m_cw);
                    chk("cw_valid",  gi, 7'(bus.cw_valid),  7'(m_cwv));
                end
            end
        end
    end

    initial begin
        logic [6:0] seq0 = 7'b1011001;   // inst 0 line order for 1011 (y6..y0)
        logic [6:0] seq1 = 7'b1100001;   // inst 1 line order for 1000 (y0..y6)
        logic [6:0] cw_fix;

        tb_reset = 1'b1;
        tb_inj   = 3'd0;
        tb_valid = '{1'b0, 1'b0};
        tb_data  = '{4'd0, 4'd0};
        repeat (3) @(negedge clk);
        chk("rst_cw",    0, o_cw[0],        7'd0);
        chk("rst_ready", 0, 7'(o_ready[0]), 7'd0);
        chk("rst_sv",    1, 7'(o_sv[1]),    7'd0);
        chk("rst_busy",  1, 7'(o_busy[1]),  7'd0);
        tb_reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 0, 7'(o_ready[0]), 7'd1);

        // First word on both instances; instance 1 keeps valid high.
        tb_data[0]  = 4'b1011;
        tb_valid[0] = 1'b1;
        tb_data[1]  = 4'b1000;
        tb_valid[1] = 1'b1;
        @(negedge clk);
        tb_valid[0] = 1'b0;
        chk("cw_1011", 0, o_cw[0],      7'b1011001);
        chk("cwv_n1",  0, 7'(o_cwv[0]), 7'd1);
        chk("cw_1000", 1, o_cw[1],      7'b1000011);
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) chk("cwv_n2", 0, 7'(o_cwv[0]), 7'd0);
            if (c < 7) begin
                chk("lit_ser", 0, 7'(o_ser[0]), 7'(seq0[6-c]));
                chk("lit_sof", 0, 7'(o_sof[0]), 7'(c == 0));
                chk("lit_eof", 0, 7'(o_eof[0]), 7'(c == 6));
            end
            if (c < 21) begin
                chk("lit_ser_div3", 1, 7'(o_ser[1]), 7'(seq1[6 - c/3]));
                chk("lit_sof_div3", 1, 7'(o_sof[1]), 7'(c < 3));
                chk("lit_eof_div3", 1, 7'(o_eof[1]), 7'(c >= 18));
            end
            if (c == 6)  chk("ready_frame_end", 0, 7'(o_ready[0]), 7'd0);
            if (c == 7)  chk("ready_back",      0, 7'(o_ready[0]), 7'd1);
            if (c == 22) chk("ready_in_gap",    1, 7'(o_ready[1]), 7'd0);
            if (c == 23) chk("ready_after_gap", 1, 7'(o_ready[1]), 7'd1);
        end
        @(negedge clk);
        tb_valid[1] = 1'b0;

        // Reset while bit 3 of a frame is on the line.
        wait_ready(0);
        tb_data[0]  = 4'b0110;
        tb_valid[0] = 1'b1;
        @(negedge clk);
        tb_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        tb_reset = 1'b1;
        @(negedge clk);
        chk("abort_sv",   0, 7'(o_sv[0]),   7'd0);
        chk("abort_busy", 0, 7'(o_busy[0]), 7'd0);
        chk("abort_cw",   0, o_cw[0],       7'd0);
        tb_reset = 1'b0;
        @(negedge clk);
        tb_data[0]  = 4'b0001;
        tb_valid[0] = 1'b1;
        @(negedge clk);
        tb_valid[0] = 1'b0;
        chk("fresh_cw", 0, o_cw[0], 7'b0001111);

        // All sixteen data words through instance 0.
        for (int d = 0; d < 16; d++) begin
            wait_ready(0);
            tb_data[0]  = 4'(d);
            tb_valid[0] = 1'b1;
            @(negedge clk);
            tb_valid[0] = 1'b0;
            chk("sweep_syndrome", 0, 7'(syndrome(o_cw[0])), 7'd0);
            chk("sweep_data",     0, 7'(o_cw[0][6:3]),      7'(d));
            case (d)
                0:       chk("enc_0000", 0, o_cw[0], 7'b0000000);
                15:      chk("enc_1111", 0, o_cw[0], 7'b1111111);
                1:       chk("enc_0001", 0, o_cw[0], 7'b0001111);
                8:       chk("enc_1000", 0, o_cw[0], 7'b1000011);
                default: ;
            endcase
        end

`ifdef HAMMING74_ERRINJ_EN
        wait_ready(0);
        tb_data[0]  = 4'b1011;
        tb_inj      = 3'd3;
        tb_valid[0] = 1'b1;
        @(negedge clk);
        tb_valid[0] = 1'b0;
        tb_inj      = 3'd0;
        chk("inj_cw", 0, o_cw[0], 7'b1011101);
        cw_fix = o_cw[0];
        for (int p = 0; p < 7; p++) begin
            if (syndrome(o_cw[0] ^ (7'd1 << p)) == 3'b000) cw_fix = o_cw[0] ^ (7'd1 << p);
        end
        chk("inj_corrected", 0, cw_fix, 7'b1011001);
`else
        cw_fix = 7'd0;
`endif

        // Randomized traffic with occasional resets; the models check it all.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                tb_valid[i] = ($urandom_range(0, 3) != 0);
                tb_data[i]  = 4'($urandom_range(0, 15));
            end
`ifdef HAMMING74_ERRINJ_EN
            tb_inj = 3'($urandom_range(0, 7));
`endif
            tb_reset = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        tb_reset = 1'b0;
        tb_valid = '{1'b0, 1'b0};
        repeat (40) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hamming74_tx.md
Name: hamming74_tx

Overview:
Transmit-side Hamming(7,4) block. It accepts 4-bit data words over a valid/ready handshake and encodes each one into a 7-bit codeword whose syndrome is 000 under the team's check equations (s2=y5^y4^y3^y2, s1=y6^y5^y3^y1, s0=y6^y4^y3^y0). Each codeword is presented in parallel and then serialized onto a one-bit line with frame markers. It sits upstream of the syndrome decoder/corrector on the same link.

Parameters:
BIT_DIV, 1, clock cycles each serial bit is held (must be >=1).
GAP_CYCLES, 0, idle cycles inserted after each frame before the next word is accepted.
MSB_FIRST, 1, 1 = transmit y6 first, 0 = transmit y0 first.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
in_data  in  4  data word d[3:0].
in_valid  in  1  in_data is valid.
in_ready  out  1  block can accept a word this cycle.
cw_out  out  7  registered codeword y[6:0].
cw_valid  out  1  one-cycle pulse when cw_out updates.
ser_out  out  1  serial codeword bit.
ser_valid  out  1  ser_out carries a codeword bit.
ser_sof  out  1  high while the first bit of a frame is on ser_out.
ser_eof  out  1  high while the last bit of a frame is on ser_out.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset is synchronous and active-high; the block has one clock, clk. At reset, every output is 0 except in_ready, which becomes 1 in the first cycle after reset deasserts. The state returns to IDLE and all counters clear.
- Encoding: y6=d3, y5=d2, y4=d1, y3=d0; y2=d2^d1^d0; y1=d3^d2^d0; y0=d3^d1^d0.
- FSM states: IDLE, SHIFT, GAP.
- IDLE: in_ready=1. A handshake (in_valid&in_ready) in cycle N has these effects:
  - the codeword is registered into cw_out and the shift register;
  - cw_valid=1 in cycle N+1 only;
  - the FSM moves to SHIFT.
  - With no handshake, the FSM stays in IDLE and ser_valid=0.
- SHIFT: in_ready=0 and ser_valid=1.
  - Bit k (k=0..6) is driven for BIT_DIV consecutive cycles. The first bit appears in cycle N+1.
  - ser_sof is high for all cycles of bit 0; ser_eof is high for all cycles of bit 6.
  - A bit counter (3 bits) and a divide counter (ceil(log2(BIT_DIV)) bits, minimum 1) track position.
  - After the last cycle of bit 6, the FSM goes to GAP if GAP_CYCLES>0, otherwise to IDLE.
- GAP: ser_valid=0 and ser_out=0. The FSM stays for exactly GAP_CYCLES cycles, then goes to IDLE.
- Frame length is 7*BIT_DIV cycles. Minimum word-to-word spacing is 7*BIT_DIV+GAP_CYCLES+1 cycles.
- ser_out is 0 whenever ser_valid=0.
- cw_out holds its last value until the next handshake.
- in_data is ignored when in_ready=0; no buffering is required.
- Reset asserted mid-frame aborts the frame. All outputs go to reset values on that same edge, and no partial frame resumes.

Optional Feature:
- Macro: HAMMING74_ERRINJ_EN.
- When defined, the block adds input port inj_pos[2:0].
  - It is sampled at the handshake.
  - A nonzero value p flips codeword bit y[p-1] in both cw_out and the serial frame.
  - A value of 0 injects nothing.
- When undefined, the port is absent and codewords are always clean.
- Purpose: lets the bench exercise the downstream corrector.

Decomposition:
- Shared package hamming74_pkg contains:
  - the FSM state enum (IDLE/SHIFT/GAP);
  - the constant CW_W=7 and DATA_W=4;
  - a function encode74(d) returning y[6:0] per the equations above.
- The decoder side reuses the same package.
- One natural sub-module: hamming74_ser. It is the shift register plus bit/divide counters, taking a load pulse and the 7-bit word and producing ser_out/sof/eof/done. The top holds the handshake, encoding and FSM.

Test Plan:
- Reset, then in_data=4'b1011 with in_valid=1 at cycle N: cw_out=7'b1011001 and cw_valid=1 at N+1. With BIT_DIV=1, MSB_FIRST=1, ser_out over N+1..N+7 is 1,0,1,1,0,0,1; sof at N+1, eof at N+7.
- Encode all 16 words: 0000->0000000, 1111->1111111, 0001->0001111, 1000->1000011. Every codeword gives syndrome 000.
- BIT_DIV=3, GAP_CYCLES=2, back-to-back in_valid: each bit lasts 3 cycles, and in_ready returns 21+2 cycles after the first bit.
- Assert reset at bit 3 of a frame: on the next edge ser_valid=0, busy=0, cw_out=0. A fresh word then transmits a complete frame.
- MSB_FIRST=0 with in_data=4'b1000: serial sequence 1,1,0,0,0,0,1 (y0..y6).
- With HAMMING74_ERRINJ_EN, in_data=4'b1011 and inj_pos=3: cw_out=7'b1011101. The decoder restores 7'b1011001.
